// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the word-port load/store unit.
//   op_e    : request opcode encoding (LB..SW), matches the 3-bit req_op field
//   state_e : controller FSM states
//   is_misaligned() : alignment check for halfword and word accesses
//   is_sub_store()  : true for byte/halfword stores (need read-modify-write)
package lsu_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WR   = 3'd2,
        S_RESP = 3'd3,
        S_ERR  = 3'd4
    } state_e;

    // Halfwords must sit on an even byte, words on a multiple of four.
    function automatic logic is_misaligned(input op_e op, input logic [1:0] addr_lo);
        case (op)
            OP_LH, OP_LHU, OP_SH: is_misaligned = addr_lo[0];
            OP_LW, OP_SW:         is_misaligned = (addr_lo != 2'b00);
            default:              is_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic is_sub_store(input op_e op);
        is_sub_store = (op == OP_SB) || (op == OP_SH);
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: combinational lane select / merge for a big-endian 32-bit word.
//   op         : request opcode
//   addr_lo    : byte offset within the word (offset 0 = bits [31:24])
//   word       : word read from memory
//   wdata      : right-justified store data
//   load_data  : sign/zero-extended load value
//   store_data : word with the addressed lane replaced (SB/SH), wdata for SW
module lsu_lane
    import lsu_pkg::*;
(
    input  op_e         op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // NOTE: every signal written in always_comb is given a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        sel_byte = word[31:24];
        case (addr_lo)
            2'd0: sel_byte = word[31:24];
            2'd1: sel_byte = word[23:16];
            2'd2: sel_byte = word[15:8];
            2'd3: sel_byte = word[7:0];
            default: sel_byte = word[31:24];
        endcase
        sel_half = addr_lo[1] ? word[15:0] : word[31:16];
    end

    always_comb begin
        load_data = '0;
        case (op)
            OP_LB:  load_data = {{24{sel_byte[7]}}, sel_byte};
            OP_LBU: load_data = {24'd0, sel_byte};
            OP_LH:  load_data = {{16{sel_half[15]}}, sel_half};
            OP_LHU: load_data = {16'd0, sel_half};
            OP_LW:  load_data = word;
            default: load_data = '0;
        endcase
    end

    always_comb begin
        store_data = word;
        case (op)
            OP_SB: begin
                case (addr_lo)
                    2'd0: store_data[31:24] = wdata[7:0];
                    2'd1: store_data[23:16] = wdata[7:0];
                    2'd2: store_data[15:8]  = wdata[7:0];
                    2'd3: store_data[7:0]   = wdata[7:0];
                    default: store_data = word;
                endcase
            end
            OP_SH: begin
                if (addr_lo[1]) store_data[15:0]  = wdata[15:0];
                else            store_data[31:16] = wdata[15:0];
            end
            OP_SW:   store_data = wdata;
            default: store_data = word;
        endcase
    end

endmodule

// File: rtl/lsu_word_port.sv
// lsu_word_port: single-outstanding load/store unit in front of a word-wide,
// big-endian data memory. Byte/halfword stores use read-modify-write.
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : request handshake (ready only in IDLE)
//   req_op/addr/wdata    : opcode, byte address, right-justified store data
//   resp_valid/rdata/err : one-cycle completion pulse, extended load data, misalign flag
//   mem_addr/wdata       : word address (low bits 0) and write word
//   mem_read/mem_write   : one-hot strobes; mem_rdata returns combinationally
module lsu_word_port
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_rdata
);

    state_e            state;
    op_e               op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       load_data;
    logic [31:0]       store_data;
    op_e               req_op_e;

    assign req_op_e = op_e'(req_op);
    assign mem_addr = {addr_q[ADDR_W-1:2], 2'b00};

    // The lane unit only ever sees the word on the bus during RD; its store
    // merge is latched into mem_wdata at that edge and driven during WR.
    lsu_lane u_lane (
        .op         (op_q),
        .addr_lo    (addr_q[1:0]),
        .word       (mem_rdata),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    // Outputs are registered and set on the edge that enters the state they
    // belong to; the async reset clears the strobes the moment rst_n falls.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            op_q       <= OP_LB;
            addr_q     <= '0;
            wdata_q    <= '0;
            mem_wdata  <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
        end else begin
            // Pulses default low each cycle.
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        op_q      <= req_op_e;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        if (is_misaligned(req_op_e, req_addr[1:0])) begin
                            state      <= S_ERR;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (req_op_e == OP_SW) begin
                            state     <= S_WR;
                            mem_write <= 1'b1;
                            mem_wdata <= req_wdata;
                        end else begin
                            state    <= S_RD;
                            mem_read <= 1'b1;
                        end
                    end
                end

                S_RD: begin
                    if (is_sub_store(op_q)) begin
                        state     <= S_WR;
                        mem_write <= 1'b1;
                        mem_wdata <= store_data;
                    end else begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_data;
                    end
                end

                S_WR: begin
                    state      <= S_RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
                end

                S_RESP, S_ERR: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end

                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_word_port.sv
// tb_lsu_word_port: directed bench for lsu_word_port with a small big-endian
// word memory model. Expected values are hand-computed constants.
module tb_lsu_word_port;
    import lsu_pkg::*;

    localparam int ADDR_W = 32;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_rdata;

    logic [31:0] mem [0:15];
    logic [3:0]  widx;

    int n_checks = 0;
    int n_fail   = 0;

    lsu_word_port #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign widx      = mem_addr[5:2];
    assign mem_rdata = mem[widx];

    always @(posedge clk) begin
        if (mem_write) mem[widx] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " req_ready"},  32'(req_ready),  32'd1);
        check({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, " resp_err"},   32'(resp_err),   32'd0);
        check({tag, " resp_rdata"}, resp_rdata,      32'd0);
        check({tag, " mem_addr"},   mem_addr,        32'd0);
        check({tag, " mem_wdata"},  mem_wdata,       32'd0);
        check({tag, " mem_read"},   32'(mem_read),   32'd0);
        check({tag, " mem_write"},  32'(mem_write),  32'd0);
    endtask

    // Issues one request and watches cycles 1..8 after the accept edge.
    // Cycle numbers: the accept edge is 0; cycle c is sampled on the negedge
    // following edge c-1. First-read/write cycles are 0 when none occurred.
    task automatic do_req(input string tag, input op_e op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input int exp_resp_cyc,
                          input int exp_rd_cyc, input int exp_wr_cyc,
                          input logic [31:0] exp_wr_addr);
        int resp_cyc, rd_cyc, wr_cyc, n_rd, n_wr;
        logic [31:0] got_rdata, got_wr_addr;
        logic got_err;
        resp_cyc = 0; rd_cyc = 0; wr_cyc = 0; n_rd = 0; n_wr = 0;
        got_rdata = 32'hx; got_err = 1'bx; got_wr_addr = 32'd0;
        @(negedge clk);
        check({tag, " ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 8 && resp_cyc == 0; c++) begin
            @(negedge clk);
            if (mem_read)  begin n_rd++; if (rd_cyc == 0) rd_cyc = c; end
            if (mem_write) begin n_wr++; if (wr_cyc == 0) wr_cyc = c; got_wr_addr = mem_addr; end
            if (resp_valid) begin
                resp_cyc  = c;
                got_rdata = resp_rdata;
                got_err   = resp_err;
            end
        end
        if (resp_cyc == 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s timeout: no resp_valid within 8 cycles", tag);
        end
        check({tag, " resp_cyc"}, 32'(resp_cyc), 32'(exp_resp_cyc));
        check({tag, " rdata"},    got_rdata,     exp_rdata);
        check({tag, " err"},      32'(got_err),  32'(exp_err));
        check({tag, " rd_cyc"},   32'(rd_cyc),   32'(exp_rd_cyc));
        check({tag, " wr_cyc"},   32'(wr_cyc),   32'(exp_wr_cyc));
        check({tag, " n_rd"},     32'(n_rd),     32'(exp_rd_cyc != 0));
        check({tag, " n_wr"},     32'(n_wr),     32'(exp_wr_cyc != 0));
        if (exp_wr_cyc != 0) check({tag, " wr_addr"}, got_wr_addr, exp_wr_addr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] ready_mask, resp_mask;
        int saw_bad;

        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (2) @(posedge clk);
        #1 check_idle_outputs("reset");
        @(negedge clk) rst_n = 1'b1;

        mem[4] = 32'h80A1C3F4;

        // Loads on word 0x10
        do_req("LB 10",  OP_LB,  32'h10, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1, 0, 32'h0);
        do_req("LBU 10", OP_LBU, 32'h10, 32'h0, 32'h00000080, 1'b0, 2, 1, 0, 32'h0);
        do_req("LB 11",  OP_LB,  32'h11, 32'h0, 32'hFFFFFFA1, 1'b0, 2, 1, 0, 32'h0);
        do_req("LBU 12", OP_LBU, 32'h12, 32'h0, 32'h000000C3, 1'b0, 2, 1, 0, 32'h0);
        do_req("LB 13",  OP_LB,  32'h13, 32'h0, 32'hFFFFFFF4, 1'b0, 2, 1, 0, 32'h0);
        do_req("LH 10",  OP_LH,  32'h10, 32'h0, 32'hFFFF80A1, 1'b0, 2, 1, 0, 32'h0);
        do_req("LH 12",  OP_LH,  32'h12, 32'h0, 32'hFFFFC3F4, 1'b0, 2, 1, 0, 32'h0);
        do_req("LHU 12", OP_LHU, 32'h12, 32'h0, 32'h0000C3F4, 1'b0, 2, 1, 0, 32'h0);
        do_req("LW 10",  OP_LW,  32'h10, 32'h0, 32'h80A1C3F4, 1'b0, 2, 1, 0, 32'h0);

        // Stores (resp_rdata must clear to 0 after the nonzero load above)
        do_req("SB 11", OP_SB, 32'h11, 32'h000000EE, 32'h0, 1'b0, 3, 1, 2, 32'h10);
        check("SB 11 mem", mem[4], 32'h80EEC3F4);
        mem[4] = 32'h80A1C3F4;
        do_req("SH 12", OP_SH, 32'h12, 32'h00001234, 32'h0, 1'b0, 3, 1, 2, 32'h10);
        check("SH 12 mem", mem[4], 32'h80A11234);
        mem[4] = 32'h80A1C3F4;
        do_req("SB 13", OP_SB, 32'h13, 32'hFFFFFF5A, 32'h0, 1'b0, 3, 1, 2, 32'h10);
        check("SB 13 mem", mem[4], 32'h80A1C35A);
        do_req("SW 14", OP_SW, 32'h14, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, 1, 32'h14);
        check("SW 14 mem", mem[5], 32'hDEADBEEF);

        // Misaligned: load first so resp_rdata is nonzero before the error
        do_req("LW 14",  OP_LW, 32'h14, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1, 0, 32'h0);
        do_req("LW 12e", OP_LW, 32'h12, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0);
        do_req("SH 13e", OP_SH, 32'h13, 32'h0000ABCD, 32'h0, 1'b1, 1, 0, 0, 32'h0);
        check("SH 13e mem", mem[4], 32'h80A1C35A);

        // Back-to-back LW with req_valid held: accepts at edges 0, 3, 6
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_LW;
        req_addr  = 32'h10;
        ready_mask = '0;
        resp_mask  = '0;
        for (int k = 0; k < 9; k++) begin
            if (k != 0) @(negedge clk);
            ready_mask[k] = req_ready;
            resp_mask[k]  = resp_valid;
            if (k < 8) @(posedge clk);
        end
        req_valid = 1'b0;
        check("b2b ready_mask", 32'(ready_mask), 32'(9'b001001001));
        check("b2b resp_mask",  32'(resp_mask),  32'(9'b100100100));

        // Reset during SB's RD cycle
        @(negedge clk);
        mem[4] = 32'h80A1C3F4;
        req_valid = 1'b1;
        req_op    = OP_SB;
        req_addr  = 32'h11;
        req_wdata = 32'h00000055;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("rst RD mem_read before", 32'(mem_read), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("rst RD mem_read drop", 32'(mem_read), 32'd0);
        saw_bad = 0;
        repeat (2) begin
            @(negedge clk);
            if (mem_write || resp_valid) saw_bad++;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (mem_write || resp_valid) saw_bad++;
        end
        check("rst no write/resp", 32'(saw_bad), 32'd0);
        check("rst mem unchanged", mem[4], 32'h80A1C3F4);
        check_idle_outputs("post-reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
